// File: rtl/diff_line_coder.sv
// ---------------------------------------------------------------------------
// diff_line_coder
//   AXI-Stream line coder for the demodulator bit path. Each beat carries
//   BITS_PER_BEAT data bits (LSB first). Four runtime modes:
//     00 DIFF_DEC  NRZI decode
//     01 DIFF_ENC  NRZI encode
//     10 DMAN_ENC  differential-Manchester encode (2 half-bits per bit)
//     11 DMAN_DEC  differential-Manchester decode with violation detection
//   A one-bit history level L chains the coding across bits and beats.
//   The mode is latched at the first beat of a packet and held until tlast.
//   Output is a single register stage: 1-cycle latency, full throughput.
//
// Ports
//   s00_axis_aclk, s00_axis_aresetn   clock, async active-low reset
//   s00_axis_*                        slave stream (tstrb ignored)
//   m00_axis_*                        master stream (tstrb all ones,
//                                     tdata zero-extended)
//   mode        coding mode, sampled at packet start
//   viol_clr    synchronous clear of viol_flag / viol_count
//   viol_flag   sticky: any DMAN_DEC violation seen
//   viol_count  saturating DMAN_DEC violation count
// ---------------------------------------------------------------------------
module diff_line_coder #(
   parameter int C_S00_AXIS_TDATA_WIDTH = 32,
   parameter int C_M00_AXIS_TDATA_WIDTH = 32,
   parameter int BITS_PER_BEAT          = 1,
   parameter bit INIT_LEVEL             = 1'b1,
   parameter bit RESET_ON_TLAST         = 1'b1
) (
   input  logic                                s00_axis_aclk,
   input  logic                                s00_axis_aresetn,
   input  logic                                s00_axis_tvalid,
   input  logic                                s00_axis_tlast,
   input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
   input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
   output logic                                s00_axis_tready,
   input  logic                                m00_axis_tready,
   output logic                                m00_axis_tvalid,
   output logic                                m00_axis_tlast,
   output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
   output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
   input  logic [1:0]                          mode,
   input  logic                                viol_clr,
   output logic                                viol_flag,
   output logic [15:0]                         viol_count
);

   typedef enum logic [1:0] {
      DIFF_DEC = 2'b00,
      DIFF_ENC = 2'b01,
      DMAN_ENC = 2'b10,
      DMAN_DEC = 2'b11
   } mode_t;

   typedef enum logic {IDLE, ACTIVE} pkt_state_t;

   localparam int NB = BITS_PER_BEAT;
   localparam int CW = 2 * NB;

   pkt_state_t                        state, state_next;
   mode_t                             active_mode, beat_mode;
   logic                              hist, hist_next, lvl;
   logic [CW-1:0]                     in_bits;
   logic [C_M00_AXIS_TDATA_WIDTH-1:0] data_next;
   logic [NB-1:0]                     viol_vec;
   logic [4:0]                        viol_n;
   logic [16:0]                       viol_sum;
   logic                              in_hs, out_hs;
   logic                              unused_inputs;

   assign s00_axis_tready = m00_axis_tready | ~m00_axis_tvalid;
   assign in_hs           = s00_axis_tvalid & s00_axis_tready;
   assign out_hs          = m00_axis_tvalid & m00_axis_tready;
   assign m00_axis_tstrb  = '1;
   assign in_bits         = s00_axis_tdata[CW-1:0];
   assign unused_inputs   = ^{s00_axis_tstrb, s00_axis_tdata};

   // The first beat of a packet is coded with the mode it presents itself.
   assign beat_mode = (state == IDLE) ? mode_t'(mode) : active_mode;

   // ---------------- bit coding, chained through the history level -------
   // NOTE: defaults are assigned first so every path writes every signal;
   // otherwise this block would infer latches.
   always_comb begin
      data_next = '0;
      viol_vec  = '0;
      viol_n    = '0;
      lvl       = hist;
      // NOTE: blocking assignments here let each bit see the level left by
      // the previous bit in the same beat; all registers use <= instead.
      for (int i = 0; i < NB; i++) begin
         case (beat_mode)
            DIFF_DEC: begin
               data_next[i] = in_bits[i] ^ lvl;
               lvl          = in_bits[i];
            end
            DIFF_ENC: begin
               data_next[i] = in_bits[i] ^ lvl;
               lvl          = data_next[i];
            end
            DMAN_ENC: begin
               data_next[2*i]   = in_bits[i] ? lvl : ~lvl;
               data_next[2*i+1] = ~data_next[2*i];
               lvl              = data_next[2*i+1];
            end
            DMAN_DEC: begin
               // No transition at the bit boundary means a 1; a missing
               // mid-bit transition is a code violation.
               data_next[i] = (in_bits[2*i] == lvl);
               viol_vec[i]  = (in_bits[2*i] == in_bits[2*i+1]);
               lvl          = in_bits[2*i+1];
            end
         endcase
         viol_n = viol_n + 5'(viol_vec[i]);
      end
      hist_next = lvl;
   end

   assign viol_sum = {1'b0, viol_count} + 17'(viol_n);

   // ---------------- packet state machine --------------------------------
   always_comb begin
      state_next = state;
      if (in_hs) state_next = s00_axis_tlast ? IDLE : ACTIVE;
   end

   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         state       <= IDLE;
         active_mode <= DIFF_DEC;
      end else begin
         state <= state_next;
         if (in_hs && state == IDLE) active_mode <= mode_t'(mode);
      end
   end

   // ---------------- output register and history -------------------------
   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         m00_axis_tvalid <= 1'b0;
         m00_axis_tlast  <= 1'b0;
         m00_axis_tdata  <= '0;
         hist            <= INIT_LEVEL;
      end else if (in_hs) begin
         m00_axis_tvalid <= 1'b1;
         m00_axis_tlast  <= s00_axis_tlast;
         m00_axis_tdata  <= data_next;
         hist            <= (s00_axis_tlast && RESET_ON_TLAST) ? INIT_LEVEL : hist_next;
      end else if (out_hs) begin
         m00_axis_tvalid <= 1'b0;
         m00_axis_tlast  <= 1'b0;
      end
   end

   // ---------------- violation accounting --------------------------------
   always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
      if (!s00_axis_aresetn) begin
         viol_flag  <= 1'b0;
         viol_count <= '0;
      end else if (viol_clr) begin
         // Clear wins over any violations arriving on the same edge.
         viol_flag  <= 1'b0;
         viol_count <= '0;
      end else if (in_hs && viol_n != 0) begin
         viol_flag  <= 1'b1;
         viol_count <= viol_sum[16] ? 16'hFFFF : viol_sum[15:0];
      end
   end

endmodule

// File: tb/tb_diff_line_coder.sv
// ---------------------------------------------------------------------------
// tb_diff_line_coder
//   Self-checking bench for diff_line_coder with BITS_PER_BEAT=4. A cycle
//   model of the stream (handshake, packet mode latch, history, violation
//   counter) predicts every output; fixed vectors and hand sequences add
//   hand-derived constants on top.
// ---------------------------------------------------------------------------
module tb_diff_line_coder;

   localparam int BPB = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s00_axis_tvalid, s00_axis_tlast, s00_axis_tready;
   logic [31:0] s00_axis_tdata;
   logic [3:0]  s00_axis_tstrb;
   logic        m00_axis_tready, m00_axis_tvalid, m00_axis_tlast;
   logic [31:0] m00_axis_tdata;
   logic [3:0]  m00_axis_tstrb;
   logic [1:0]  mode;
   logic        viol_clr, viol_flag;
   logic [15:0] viol_count;

   diff_line_coder #(
      .C_S00_AXIS_TDATA_WIDTH(32),
      .C_M00_AXIS_TDATA_WIDTH(32),
      .BITS_PER_BEAT(BPB),
      .INIT_LEVEL(1'b1),
      .RESET_ON_TLAST(1'b1)
   ) dut (
      .s00_axis_aclk(clk),
      .s00_axis_aresetn(rst_n),
      .s00_axis_tvalid(s00_axis_tvalid),
      .s00_axis_tlast(s00_axis_tlast),
      .s00_axis_tdata(s00_axis_tdata),
      .s00_axis_tstrb(s00_axis_tstrb),
      .s00_axis_tready(s00_axis_tready),
      .m00_axis_tready(m00_axis_tready),
      .m00_axis_tvalid(m00_axis_tvalid),
      .m00_axis_tlast(m00_axis_tlast),
      .m00_axis_tdata(m00_axis_tdata),
      .m00_axis_tstrb(m00_axis_tstrb),
      .mode(mode),
      .viol_clr(viol_clr),
      .viol_flag(viol_flag),
      .viol_count(viol_count)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic        e_valid, e_last, m_l, m_in_pkt, m_flag;
   logic [31:0] e_data;
   logic [1:0]  m_amode;
   int          m_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One beat coded from the line-coding rules, viewed as signal levels.
   function automatic void model_beat(input logic [1:0] md, input logic [31:0] din,
                                      input logic l_in, output logic [31:0] dout,
                                      output logic l_out, output int nv);
      logic lvl;
      dout = '0;
      nv   = 0;
      lvl  = l_in;
      case (md)
         2'b00: begin  // each output bit says "did the line change?"
            dout[BPB-1:0] = din[BPB-1:0] ^ {din[BPB-2:0], l_in};
            lvl           = din[BPB-1];
         end
         2'b01: begin  // line level is running parity of data bits
            for (int i = 0; i < BPB; i++) begin
               lvl     = lvl ^ din[i];
               dout[i] = lvl;
            end
         end
         2'b10: begin  // 0 = toggle at bit start; always toggle mid-bit
            for (int i = 0; i < BPB; i++) begin
               if (!din[i]) lvl = ~lvl;
               dout[2*i]   = lvl;
               lvl         = ~lvl;
               dout[2*i+1] = lvl;
            end
         end
         default: begin  // decode: 1 = no boundary toggle; no mid toggle = violation
            for (int i = 0; i < BPB; i++) begin
               dout[i] = (din[2*i] == lvl);
               if (din[2*i] == din[2*i+1]) nv++;
               lvl = din[2*i+1];
            end
         end
      endcase
      l_out = lvl;
   endfunction

   task automatic model_reset();
      e_valid  = 1'b0;
      e_last   = 1'b0;
      e_data   = '0;
      m_l      = 1'b1;
      m_in_pkt = 1'b0;
      m_amode  = 2'b00;
      m_cnt    = 0;
      m_flag   = 1'b0;
   endtask

   // Called at edge+1: drive, predict, clock, compare.
   task automatic step(input logic v, input logic [31:0] d, input logic lst,
                       input logic mr, input logic [1:0] md, input logic clr);
      logic        exp_ready, hs_in, hs_out, new_l;
      logic [1:0]  md_eff;
      logic [31:0] res;
      int          nv;
      s00_axis_tvalid = v;
      s00_axis_tdata  = d;
      s00_axis_tlast  = lst;
      m00_axis_tready = mr;
      mode            = md;
      viol_clr        = clr;
      #1;
      exp_ready = mr | ~e_valid;
      check("s_tready", {31'b0, s00_axis_tready}, {31'b0, exp_ready});
      hs_in  = v & exp_ready;
      hs_out = e_valid & mr;
      md_eff = m_in_pkt ? m_amode : md;
      nv     = 0;
      if (hs_in) begin
         if (!m_in_pkt) m_amode = md;
         model_beat(md_eff, d, m_l, res, new_l, nv);
         m_l      = lst ? 1'b1 : new_l;
         m_in_pkt = !lst;
         e_valid  = 1'b1;
         e_data   = res;
         e_last   = lst;
      end else if (hs_out) begin
         e_valid = 1'b0;
         e_last  = 1'b0;
      end
      if (clr) begin
         m_cnt  = 0;
         m_flag = 1'b0;
      end else if (hs_in && nv > 0) begin
         m_cnt  = (m_cnt + nv > 65535) ? 65535 : m_cnt + nv;
         m_flag = 1'b1;
      end
      @(posedge clk);
      #1;
      check("m_tvalid", {31'b0, m00_axis_tvalid}, {31'b0, e_valid});
      if (e_valid) begin
         check("m_tdata", m00_axis_tdata, e_data);
         check("m_tlast", {31'b0, m00_axis_tlast}, {31'b0, e_last});
      end
      check("viol_count", {16'b0, viol_count}, m_cnt);
      check("viol_flag", {31'b0, viol_flag}, {31'b0, m_flag});
   endtask

   typedef struct {
      logic [1:0]  md;
      logic [31:0] din;
      logic        lst;
      logic        clr;
      logic [31:0] dout;
      logic [15:0] cnt;
      logic        flg;
   } vec_t;

   vec_t tbl [10];
   int   n_out;

   initial begin
      // Expected values derived by hand from the coding rules, L starts at 1.
      tbl[0] = '{2'b00, 32'h06, 1'b0, 1'b0, 32'h0B, 16'd0, 1'b0};
      tbl[1] = '{2'b00, 32'h00, 1'b1, 1'b0, 32'h00, 16'd0, 1'b0};
      tbl[2] = '{2'b01, 32'h06, 1'b1, 1'b0, 32'h0D, 16'd0, 1'b0};
      tbl[3] = '{2'b10, 32'h02, 1'b1, 1'b0, 32'h56, 16'd0, 1'b0};
      tbl[4] = '{2'b11, 32'h56, 1'b1, 1'b0, 32'h02, 16'd0, 1'b0};
      tbl[5] = '{2'b11, 32'h57, 1'b0, 1'b0, 32'h03, 16'd1, 1'b1};
      tbl[6] = '{2'b11, 32'h57, 1'b1, 1'b1, 32'h02, 16'd0, 1'b0};
      tbl[7] = '{2'b00, 32'h06, 1'b0, 1'b0, 32'h0B, 16'd0, 1'b0};
      tbl[8] = '{2'b01, 32'h06, 1'b1, 1'b0, 32'h0A, 16'd0, 1'b0};  // mode change ignored
      tbl[9] = '{2'b01, 32'h06, 1'b1, 1'b0, 32'h0D, 16'd0, 1'b0};  // new packet, L=1

      rst_n           = 1'b0;
      s00_axis_tvalid = 1'b0;
      s00_axis_tlast  = 1'b0;
      s00_axis_tdata  = '0;
      s00_axis_tstrb  = '0;
      m00_axis_tready = 1'b0;
      mode            = 2'b00;
      viol_clr        = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_tvalid", {31'b0, m00_axis_tvalid}, 32'd0);
      check("rst_tlast", {31'b0, m00_axis_tlast}, 32'd0);
      check("rst_tdata", m00_axis_tdata, 32'd0);
      check("rst_viol_count", {16'b0, viol_count}, 32'd0);
      check("rst_viol_flag", {31'b0, viol_flag}, 32'd0);
      check("tstrb", {28'b0, m00_axis_tstrb}, 32'hF);
      rst_n = 1'b1;

      // ---- directed vectors ----
      for (int i = 0; i < 10; i++) begin
         step(1'b1, tbl[i].din, tbl[i].lst, 1'b1, tbl[i].md, tbl[i].clr);
         check($sformatf("vec%0d_tdata", i), m00_axis_tdata, tbl[i].dout);
         check($sformatf("vec%0d_count", i), {16'b0, viol_count}, {16'b0, tbl[i].cnt});
         check($sformatf("vec%0d_flag", i), {31'b0, viol_flag}, {31'b0, tbl[i].flg});
      end
      step(1'b0, 32'h0, 1'b0, 1'b1, 2'b00, 1'b0);

      // ---- backpressure: output must hold, input must stall ----
      step(1'b1, 32'h06, 1'b1, 1'b0, 2'b01, 1'b0);
      check("bp_first", m00_axis_tdata, 32'h0D);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 32'h00, 1'b1, 1'b0, 2'b01, 1'b0);
         check("bp_hold_data", m00_axis_tdata, 32'h0D);
         check("bp_hold_ready", {31'b0, s00_axis_tready}, 32'd0);
      end
      step(1'b1, 32'h00, 1'b1, 1'b1, 2'b01, 1'b0);
      check("bp_replace", m00_axis_tdata, 32'h0F);
      step(1'b0, 32'h0, 1'b0, 1'b1, 2'b00, 1'b0);

      // ---- violation counter saturation: 4 violations per beat ----
      for (int i = 0; i < 16385; i++) step(1'b1, 32'h00, 1'b0, 1'b1, 2'b11, 1'b0);
      check("sat_count", {16'b0, viol_count}, 32'h0000FFFF);
      check("sat_flag", {31'b0, viol_flag}, 32'd1);
      step(1'b1, 32'h00, 1'b1, 1'b1, 2'b11, 1'b0);
      step(1'b0, 32'h00, 1'b0, 1'b1, 2'b00, 1'b1);
      check("clr_alone", {16'b0, viol_count}, 32'd0);

      // ---- random traffic against the model ----
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(3) != 0), $urandom, ($urandom_range(3) == 0),
              ($urandom_range(3) != 0), 2'($urandom_range(3)), ($urandom_range(15) == 0));
      end
      step(1'b0, 32'h0, 1'b0, 1'b1, 2'b00, 1'b0);
      step(1'b1, 32'h0, 1'b1, 1'b1, 2'b00, 1'b0);  // close any open packet

      // ---- 100 back-to-back beats, then reset mid-packet ----
      n_out = 0;
      for (int i = 0; i < 100; i++) begin
         step(1'b1, $urandom, (i % 7 == 6), 1'b1, 2'b00, 1'b0);
         if (m00_axis_tvalid) n_out++;
      end
      check("b2b_count", n_out, 32'd100);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst_tvalid", {31'b0, m00_axis_tvalid}, 32'd0);
      check("async_rst_tdata", m00_axis_tdata, 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b1, 32'h06, 1'b1, 1'b1, 2'b01, 1'b0);
      check("post_rst_idle_mode", m00_axis_tdata, 32'h0D);
      step(1'b0, 32'h0, 1'b0, 1'b1, 2'b00, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
